// File: rtl/mem_store_serializer_pkg.sv
// rtl/mem_store_serializer_pkg.sv - shared SIZE encodings, FSM state type and store helpers
package mem_store_serializer_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_FINISH = 2'd2,
        ST_FAULT  = 2'd3
    } state_e;

    // Index of the final byte of a store: one less than its byte count.
    function automatic logic [1:0] last_byte_idx(input logic [1:0] size);
        logic [1:0] idx;
        case (size)
            SZ_HALF: idx = 2'd1;
            SZ_WORD: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic store_rejected(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_byte_sel.sv
// rtl/store_byte_sel.sv - picks byte idx of a 32-bit store word, little-endian
module store_byte_sel (
    input  logic [31:0] data_i,
    input  logic [1:0]  idx_i,
    output logic [7:0]  byte_o
);

    always_comb begin
        byte_o = 8'h00;
        case (idx_i)
            2'd0: byte_o = data_i[7:0];
            2'd1: byte_o = data_i[15:8];
            2'd2: byte_o = data_i[23:16];
            2'd3: byte_o = data_i[31:24];
            default: byte_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/mem_store_serializer.sv
// rtl/mem_store_serializer.sv - serializes byte/halfword/word stores into byte writes
module mem_store_serializer
    import mem_store_serializer_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [1:0]        SIZE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [31:0]       DATA,
    input  logic              MEM_READY,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [7:0]        MEM_WDATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        idx_q, idx_d;
    logic [7:0]        sel_byte;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        last_d  = last_q;
        idx_d   = idx_q;
        MEM_WE  = 1'b0;
        DONE    = 1'b0;
        ERR     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    if (store_rejected(SIZE, ADDR[1:0])) begin
                        state_d = ST_FAULT;
                    end else begin
                        addr_d  = ADDR;
                        data_d  = DATA;
                        last_d  = last_byte_idx(SIZE);
                        idx_d   = 2'd0;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                MEM_WE = 1'b1;
                if (MEM_READY) begin
                    if (idx_q == last_q) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            ST_FINISH: begin
                DONE    = 1'b1;
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                ERR     = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    store_byte_sel u_byte_sel (
        .data_i (data_q),
        .idx_i  (idx_q),
        .byte_o (sel_byte)
    );

    // Address and data buses read as zero outside WRITE so reset/idle values are clean.
    assign MEM_ADDR  = MEM_WE ? (addr_q + ADDR_W'(idx_q)) : '0;
    assign MEM_WDATA = MEM_WE ? sel_byte : 8'h00;
    assign BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_store_serializer.sv
// tb/tb_mem_store_serializer.sv - randomized self-checking bench for mem_store_serializer
module tb_mem_store_serializer;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [1:0]  SIZE;
    logic [31:0] ADDR;
    logic [31:0] DATA;
    logic        MEM_READY;
    logic        MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [7:0]  MEM_WDATA;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    int checks = 0;
    int errors = 0;

    mem_store_serializer #(.ADDR_W(32)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
        .SIZE      (SIZE),
        .ADDR      (ADDR),
        .DATA      (DATA),
        .MEM_READY (MEM_READY),
        .MEM_WE    (MEM_WE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Runs one request from a negedge with the DUT idle; returns at a negedge with the DUT idle.
    // mode: 0 ready always high, 1 random ready, 2 ready low for the first two write cycles.
    task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                            input int mode, input bit poke);
        int    n;
        int    idx;
        bit    fault;
        bit    done_seen;
        bit    fin;
        bit    rdy;
        logic [31:0] exp_addr;
        logic [7:0]  exp_byte;

        n         = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        fault     = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        idx       = 0;
        done_seen = 1'b0;
        fin       = 1'b0;

        START = 1'b1; SIZE = sz; ADDR = a; DATA = d; MEM_READY = 1'b1;
        @(posedge CLK); #1;
        START = poke;
        ADDR  = $urandom;
        DATA  = $urandom;
        SIZE  = 2'($urandom_range(0, 2));

        for (int cyc = 0; cyc < 80 && !fin; cyc++) begin
            @(negedge CLK);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (cyc >= 2);
            endcase
            MEM_READY = rdy;
            if (fault) begin
                if (cyc == 0) begin
                    check("fault_err",  ERR,    1);
                    check("fault_we",   MEM_WE, 0);
                    check("fault_done", DONE,   0);
                    check("fault_busy", BUSY,   1);
                    START = 1'b0;
                end else begin
                    check("fault_idle_busy", BUSY, 0);
                    check("fault_idle_err",  ERR,  0);
                    check("fault_idle_we",   MEM_WE, 0);
                    fin = 1'b1;
                end
            end else if (idx < n) begin
                exp_addr = a + 32'(idx);
                exp_byte = 8'((d >> (8 * idx)) & 32'hFF);
                check("wr_we",    MEM_WE,    1);
                check("wr_addr",  MEM_ADDR,  exp_addr);
                check("wr_data",  MEM_WDATA, exp_byte);
                check("wr_done",  DONE,      0);
                check("wr_err",   ERR,       0);
                check("wr_busy",  BUSY,      1);
                if (rdy) idx++;
            end else if (!done_seen) begin
                check("fin_done", DONE,   1);
                check("fin_we",   MEM_WE, 0);
                check("fin_err",  ERR,    0);
                check("fin_busy", BUSY,   1);
                done_seen = 1'b1;
                START     = 1'b0;
            end else begin
                check("idle_busy", BUSY,   0);
                check("idle_done", DONE,   0);
                check("idle_we",   MEM_WE, 0);
                fin = 1'b1;
            end
        end
        if (!fin) check("timeout", 0, 1);
        START = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0; START = 1'b0; SIZE = 2'b00; ADDR = '0; DATA = '0; MEM_READY = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_we",    MEM_WE,    0);
        check("rst_addr",  MEM_ADDR,  0);
        check("rst_wdata", MEM_WDATA, 0);
        check("rst_busy",  BUSY,      0);
        check("rst_done",  DONE,      0);
        check("rst_err",   ERR,       0);

        RST_N = 1'b1;
        do_store(2'b10, 32'h0000_0100, 32'hA1B2_C3D4, 0, 1'b0);
        do_store(2'b01, 32'h0000_0022, 32'hFFFF_5A6B, 2, 1'b0);
        do_store(2'b10, 32'h0000_0102, 32'h1234_5678, 0, 1'b0);
        do_store(2'b11, $urandom,      32'h8765_4321, 0, 1'b0);
        do_store(2'b00, 32'hFFFF_FFFF, 32'h0000_0077, 0, 1'b1);

        // Abort a word store just after byte 1 is accepted.
        START = 1'b1; SIZE = 2'b10; ADDR = 32'h0000_0200; DATA = 32'hCAFE_F00D; MEM_READY = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        @(negedge CLK);
        check("abort_b0", MEM_WDATA, 8'h0D);
        @(negedge CLK);
        check("abort_b1", MEM_WDATA, 8'hF0);
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("abort_we",   MEM_WE,   0);
        check("abort_busy", BUSY,     0);
        check("abort_done", DONE,     0);
        check("abort_err",  ERR,      0);
        check("abort_addr", MEM_ADDR, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        do_store(2'b00, 32'h0000_0345, 32'h0000_00E9, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            do_store(2'($urandom_range(0, 3)), $urandom, $urandom, 1, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
